// File: rtl/negate_add_sequencer.sv
// negate_add_sequencer
//   Multi-cycle arithmetic controller built around one WIDTH-bit adder
//   (A + B + cin) with operand inversion. It sequences ADD, SUB, NEG, ABS
//   and unsigned shift-add MULU through that single adder.
//
// Handshake: start is taken only while busy=0 (state IDLE or DONE). On that
//   edge Ra/Rb/op are latched. busy is high while the operation runs. done
//   is high for exactly one cycle (state DONE), and the results are valid
//   then. A new start in the DONE cycle is accepted at once. A start while
//   busy is dropped and is not queued.
//
// Ports:
//   clk, reset    rising-edge clock, synchronous active-high reset
//   start, op     request and opcode (000 ADD, 001 SUB, 010 NEG, 011 ABS,
//                 100 MULU, others illegal)
//   Ra, Rb        operands
//   busy, done    status (busy in EXEC/ABS_FIX/MUL_ITER, done in DONE)
//   Rz, Rz_hi     result (Rz_hi is the MULU high half, 0 otherwise)
//   cout, ovf     adder carry-out and overflow flag
//   err           illegal opcode
module negate_add_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] Ra,
    input  logic [WIDTH-1:0] Rb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Rz,
    output logic [WIDTH-1:0] Rz_hi,
    output logic             cout,
    output logic             ovf,
    output logic             err
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_NEG  = 3'b010;
    localparam logic [2:0] OP_ABS  = 3'b011;
    localparam logic [2:0] OP_MULU = 3'b100;
    localparam int         CW      = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_EXEC, S_ABS_FIX, S_MUL_ITER, S_DONE
    } state_t;

    state_t           state;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] ra_q;
    logic [WIDTH-1:0] rb_q;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic             abs_neg;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH:0]   sum;
    logic             accept;

    assign busy   = (state == S_EXEC) || (state == S_ABS_FIX) || (state == S_MUL_ITER);
    assign done   = (state == S_DONE);
    assign accept = start && ((state == S_IDLE) || (state == S_DONE));

    // Operand steering for the one shared adder. Negation is ~x + 1, so it
    // reuses the adder with the inverted operand and cin=1.
    always_comb begin
        add_a   = ra_q;
        add_b   = '0;
        add_cin = 1'b0;
        case (state)
            S_EXEC: begin
                case (op_q)
                    OP_ADD: add_b = rb_q;
                    OP_SUB: begin
                        add_b   = ~rb_q;
                        add_cin = 1'b1;
                    end
                    OP_NEG: begin
                        add_a   = ~ra_q;
                        add_cin = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_ABS_FIX: begin
                if (abs_neg) begin
                    add_a   = ~ra_q;
                    add_cin = 1'b1;
                end
            end
            S_MUL_ITER: begin
                add_a = acc_hi;
                add_b = acc_lo[0] ? ra_q : '0;
            end
            default: ;
        endcase
    end

    assign sum = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            op_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            abs_neg <= 1'b0;
            cnt     <= '0;
            Rz      <= '0;
            Rz_hi   <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        op_q <= op;
                        ra_q <= Ra;
                        rb_q <= Rb;
                        if (op == OP_MULU) begin
                            acc_hi <= '0;
                            acc_lo <= Rb;
                            cnt    <= '0;
                            state  <= S_MUL_ITER;
                        end else begin
                            state <= S_EXEC;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_EXEC: begin
                    Rz_hi <= '0;
                    err   <= 1'b0;
                    state <= S_DONE;
                    case (op_q)
                        OP_ADD: begin
                            Rz   <= sum[WIDTH-1:0];
                            cout <= sum[WIDTH];
                            ovf  <= (ra_q[WIDTH-1] == rb_q[WIDTH-1]) &&
                                    (sum[WIDTH-1] != ra_q[WIDTH-1]);
                        end
                        OP_SUB: begin
                            Rz   <= sum[WIDTH-1:0];
                            cout <= sum[WIDTH];
                            ovf  <= (ra_q[WIDTH-1] != rb_q[WIDTH-1]) &&
                                    (sum[WIDTH-1] != ra_q[WIDTH-1]);
                        end
                        OP_NEG: begin
                            Rz   <= sum[WIDTH-1:0];
                            cout <= sum[WIDTH];
                            // Only 100..0 stays negative after negation.
                            ovf  <= ra_q[WIDTH-1] && sum[WIDTH-1];
                        end
                        OP_ABS: begin
                            abs_neg <= ra_q[WIDTH-1];
                            state   <= S_ABS_FIX;
                        end
                        default: begin
                            Rz   <= '0;
                            cout <= 1'b0;
                            ovf  <= 1'b0;
                            err  <= 1'b1;
                        end
                    endcase
                end
                S_ABS_FIX: begin
                    Rz    <= sum[WIDTH-1:0];
                    Rz_hi <= '0;
                    cout  <= sum[WIDTH];
                    ovf   <= abs_neg && sum[WIDTH-1];
                    err   <= 1'b0;
                    state <= S_DONE;
                end
                S_MUL_ITER: begin
                    // Step 0 is a settle step on the freshly loaded
                    // accumulator; steps 1..WIDTH each add Ra (if the
                    // multiplier LSB is set) and shift {carry,acc_hi,acc_lo}
                    // right by one.
                    cnt <= cnt + CW'(1);
                    if (cnt != '0) begin
                        acc_hi <= sum[WIDTH:1];
                        acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
                        if (cnt == CW'(WIDTH)) begin
                            Rz    <= {sum[0], acc_lo[WIDTH-1:1]};
                            Rz_hi <= sum[WIDTH:1];
                            cout  <= 1'b0;
                            ovf   <= |sum[WIDTH:1];
                            err   <= 1'b0;
                            state <= S_DONE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_negate_add_sequencer.sv
// tb_negate_add_sequencer
//   Directed bench for negate_add_sequencer (WIDTH=32). Drivers issue
//   operations and push the hand-computed response plus latency onto a
//   queue; a monitor pops and compares on every done pulse.
module tb_negate_add_sequencer;

    localparam int W  = 32;
    localparam int EW = 8 + 3 + 2 * W;  // {lat, err, ovf, cout, rz_hi, rz}

    logic         clk;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] Ra;
    logic [W-1:0] Rb;
    logic         busy;
    logic         done;
    logic [W-1:0] Rz;
    logic [W-1:0] Rz_hi;
    logic         cout;
    logic         ovf;
    logic         err;

    logic [EW-1:0] exp_q[$];
    int            acc_q[$];
    int            cyc;
    int            total;
    int            bad;
    int            prev_done;
    int            last_done;

    negate_add_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .Ra    (Ra),
        .Rb    (Rb),
        .busy  (busy),
        .done  (done),
        .Rz    (Rz),
        .Rz_hi (Rz_hi),
        .cout  (cout),
        .ovf   (ovf),
        .err   (err)
    );

    // Clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Driver: wait until idle/done, present one request, push expectation.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] e_rz, input logic [W-1:0] e_hi,
                         input logic e_c, input logic e_o, input logic e_e, input int e_lat);
        int g;
        g = 0;
        while (busy && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) chk("issue_wait", 64'(busy), 64'd0);
        start = 1'b1;
        op    = o;
        Ra    = a;
        Rb    = b;
        @(posedge clk);
        #1;
        exp_q.push_back({8'(e_lat), e_e, e_o, e_c, e_hi, e_rz});
        acc_q.push_back(cyc);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
    endtask

    // Monitor / scoreboard
    initial begin
        logic [EW-1:0] e;
        int            a;
        prev_done = 0;
        last_done = 0;
        forever begin
            @(negedge clk);
            if (!reset && done) begin
                prev_done = last_done;
                last_done = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    chk("rz",      64'(Rz),       64'(e[W-1:0]));
                    chk("rz_hi",   64'(Rz_hi),    64'(e[2*W-1:W]));
                    chk("cout",    64'(cout),     64'(e[2*W]));
                    chk("ovf",     64'(ovf),      64'(e[2*W+1]));
                    chk("err",     64'(err),      64'(e[2*W+2]));
                    chk("latency", 64'(cyc - a + 1), 64'(e[EW-1:2*W+3]));
                end
            end
        end
    end

    // Stimulus
    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        start = 1'b0;
        op    = '0;
        Ra    = '0;
        Rb    = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy",  64'(busy),  64'd0);
        chk("rst_done",  64'(done),  64'd0);
        chk("rst_rz",    64'(Rz),    64'd0);
        chk("rst_rz_hi", 64'(Rz_hi), 64'd0);
        chk("rst_flags", 64'({cout, ovf, err}), 64'd0);
        @(negedge clk);

        //     op      Ra            Rb            Rz            Rz_hi         c     o     e   lat
        issue(3'b000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0,        1'b0, 1'b1, 1'b0, 2);
        issue(3'b001, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 32'h0,        1'b0, 1'b0, 1'b0, 2);
        issue(3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0,        1'b1, 1'b0, 1'b0, 2);
        issue(3'b001, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0,        1'b1, 1'b1, 1'b0, 2);
        issue(3'b010, 32'h00000000, 32'h12345678, 32'h00000000, 32'h0,        1'b1, 1'b0, 1'b0, 2);
        issue(3'b010, 32'h80000000, 32'h0,        32'h80000000, 32'h0,        1'b0, 1'b1, 1'b0, 2);
        issue(3'b010, 32'h00000005, 32'h0,        32'hFFFFFFFB, 32'h0,        1'b0, 1'b0, 1'b0, 2);
        issue(3'b011, 32'hFFFFFFF6, 32'hDEADBEEF, 32'h0000000A, 32'h0,        1'b0, 1'b0, 1'b0, 3);
        issue(3'b011, 32'h00000009, 32'h0,        32'h00000009, 32'h0,        1'b0, 1'b0, 1'b0, 3);
        issue(3'b011, 32'h80000000, 32'h0,        32'h80000000, 32'h0,        1'b0, 1'b1, 1'b0, 3);
        issue(3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b1, 1'b0, 34);
        issue(3'b100, 32'h00000003, 32'h00000004, 32'h0000000C, 32'h0,        1'b0, 1'b0, 1'b0, 34);
        issue(3'b110, 32'h00001234, 32'h00005678, 32'h00000000, 32'h0,        1'b0, 1'b0, 1'b1, 2);
        issue(3'b000, 32'h00000001, 32'h00000002, 32'h00000003, 32'h0,        1'b0, 1'b0, 1'b0, 2);
        wait_drain();

        // Back-to-back ADDs: second start lands in the DONE cycle of the first.
        issue(3'b000, 32'h00000001, 32'h00000002, 32'h00000003, 32'h0,        1'b0, 1'b0, 1'b0, 2);
        issue(3'b000, 32'h00000010, 32'h00000020, 32'h00000030, 32'h0,        1'b0, 1'b0, 1'b0, 2);
        wait_drain();
        chk("b2b_gap", 64'(last_done - prev_done), 64'd2);

        // start held high while busy must be ignored.
        issue(3'b100, 32'h00000007, 32'h00000006, 32'h0000002A, 32'h0,        1'b0, 1'b0, 1'b0, 34);
        start = 1'b1;
        op    = 3'b000;
        Ra    = 32'h1;
        Rb    = 32'h1;
        repeat (10) @(negedge clk);
        start = 1'b0;
        wait_drain();
        repeat (3) @(negedge clk);
        chk("held_start_queue", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of a MULU: no done, all outputs cleared.
        @(negedge clk);
        start = 1'b1;
        op    = 3'b100;
        Ra    = 32'hFFFFFFFF;
        Rb    = 32'hFFFFFFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_busy", 64'(busy), 64'd0);
            chk("midrst_done", 64'(done), 64'd0);
        end
        chk("midrst_rz",    64'(Rz),    64'd0);
        chk("midrst_flags", 64'({cout, ovf, err}), 64'd0);
        reset = 1'b0;
        repeat (40) begin
            @(negedge clk);
            chk("post_rst_idle", 64'({busy, done}), 64'd0);
        end

        issue(3'b001, 32'h00000010, 32'h00000003, 32'h0000000D, 32'h0,        1'b1, 1'b0, 1'b0, 2);
        wait_drain();
        chk("final_queue", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
